// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: datapath widths, opcode encodings and
// the memory access controller FSM state encoding.
package cpu_pkg;

    localparam int unsigned RegisterWidth      = 4;
    localparam int unsigned MemoryAddressWidth = 4;

    // Opcode map; NOP must stay 0000 so a reset instruction register is harmless.
    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpLd  = 4'b0001;
    localparam logic [3:0] OpSt  = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSub = 4'b0100;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpOr  = 4'b0110;
    localparam logic [3:0] OpXor = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1000;
    localparam logic [3:0] OpShl = 4'b1001;
    localparam logic [3:0] OpShr = 4'b1010;
    localparam logic [3:0] OpJmp = 4'b1011;
    localparam logic [3:0] OpJz  = 4'b1100;
    localparam logic [3:0] OpJc  = 4'b1101;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpLdi = 4'b1111;

    // Memory access controller FSM states.
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StRespF = 3'd3;
    localparam logic [2:0] StRespD = 3'd4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the core, the memory access controller and the register
// memory. Signal names keep the controller's point of view (_i into it, _o out).
//   slave  : controller view (requests and memory read data in; strobes/results out)
//   master : core + memory view (drives requests and read data, observes the rest)
interface mem_access_ctrl_if #(
    parameter int unsigned REGISTER_WIDTH       = 4,
    parameter int unsigned MEMORY_ADDRESS_WIDTH = 4
);
    logic                            fetch_req_i;
    logic                            jump_en_i;
    logic [MEMORY_ADDRESS_WIDTH-1:0] jump_addr_i;
    logic                            data_req_i;
    logic                            data_we_i;
    logic [MEMORY_ADDRESS_WIDTH-1:0] data_addr_i;
    logic [REGISTER_WIDTH-1:0]       data_wdata_i;
    logic [REGISTER_WIDTH-1:0]       mem_data_i;
    logic                            mem_read_en_o;
    logic                            mem_write_en_o;
    logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [REGISTER_WIDTH-1:0]       mem_data_o;
    logic [REGISTER_WIDTH-1:0]       instr_o;
    logic [MEMORY_ADDRESS_WIDTH-1:0] pc_o;
    logic                            fetch_valid_o;
    logic [REGISTER_WIDTH-1:0]       data_rdata_o;
    logic                            data_valid_o;
    logic                            busy_o;

    modport slave (
        input  fetch_req_i, jump_en_i, jump_addr_i, data_req_i, data_we_i, data_addr_i,
               data_wdata_i, mem_data_i,
        output mem_read_en_o, mem_write_en_o, mem_addr_o, mem_data_o, instr_o, pc_o,
               fetch_valid_o, data_rdata_o, data_valid_o, busy_o
    );

    modport master (
        output fetch_req_i, jump_en_i, jump_addr_i, data_req_i, data_we_i, data_addr_i,
               data_wdata_i, mem_data_i,
        input  mem_read_en_o, mem_write_en_o, mem_addr_o, mem_data_o, instr_o, pc_o,
               fetch_valid_o, data_rdata_o, data_valid_o, busy_o
    );

endinterface

// File: rtl/mem_access_ctrl_prog_counter.sv
// Program counter: loads a jump target or increments, wrapping modulo 2^Width.
//   clk_i/reset_i : clock, async active-high reset (pc -> 0)
//   load_i        : take load_addr_i (wins over inc_i)
//   inc_i         : advance by one
//   pc_o          : current PC
module prog_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_addr_i,
    input  logic             inc_i,
    output logic [Width-1:0] pc_o
);

    logic [Width-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + Width'(1);  // natural wrap, no carry out
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single initiator on the register memory port. Serves instruction fetch and
// LD/ST from the core: level-held requests become one-cycle memory strobes, and
// results come back registered with a one-cycle valid pulse.
//   clk_i/reset_i : clock, async active-high reset (aborts any access)
//   bus           : request/response and memory port bundle (slave view)
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH       = RegisterWidth,
    parameter int unsigned MEMORY_ADDRESS_WIDTH = MemoryAddressWidth
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_access_ctrl_if.slave  bus
);

    logic [2:0]                      state_d, state_q;
    logic                            we_d, we_q;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_d, addr_q;
    logic [REGISTER_WIDTH-1:0]       wdata_d, wdata_q;
    logic [REGISTER_WIDTH-1:0]       instr_d, instr_q;
    logic [REGISTER_WIDTH-1:0]       rdata_d, rdata_q;
    logic                            pc_load, pc_inc;
    logic [MEMORY_ADDRESS_WIDTH-1:0] pc;

    prog_counter #(
        .Width (MEMORY_ADDRESS_WIDTH)
    ) u_prog_counter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (pc_load),
        .load_addr_i (bus.jump_addr_i),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    // Next-state: requests are only looked at in IDLE; jump beats data beats fetch.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.jump_en_i) begin
                    pc_load = 1'b1;
                end else if (bus.data_req_i) begin
                    we_d    = bus.data_we_i;
                    addr_d  = bus.data_addr_i;
                    wdata_d = bus.data_wdata_i;
                    state_d = StData;
                end else if (bus.fetch_req_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                instr_d = bus.mem_data_i;
                pc_inc  = 1'b1;
                state_d = StRespF;
            end
            StData: begin
                rdata_d = we_q ? '0 : bus.mem_data_i;
                state_d = StRespD;
            end
            default: state_d = StIdle;  // both RESP states, plus illegal codes
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory port is decoded from state so reset drops strobes asynchronously.
    always_comb begin
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        bus.mem_addr_o     = '0;
        bus.mem_data_o     = '0;
        case (state_q)
            StFetch: begin
                bus.mem_read_en_o = 1'b1;
                bus.mem_addr_o    = pc;
            end
            StData: begin
                bus.mem_read_en_o  = ~we_q;
                bus.mem_write_en_o = we_q;
                bus.mem_addr_o     = addr_q;
                bus.mem_data_o     = we_q ? wdata_q : '0;
            end
            default: ;
        endcase
    end

    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc;
    assign bus.data_rdata_o  = rdata_q;
    assign bus.fetch_valid_o = (state_q == StRespF);
    assign bus.data_valid_o  = (state_q == StRespD);
    assign bus.busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl paired with a 16x4 register memory model.
module tb_mem_access_ctrl;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl_if #(.REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4)) bus ();

    mem_access_ctrl dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // Register memory responder: combinational read, write at end of the strobe cycle.
    logic [3:0] mem [16];
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
            mem[0] <= 4'b1110;
            mem[1] <= 4'b0101;
            mem[2] <= 4'b1010;
        end else if (bus.mem_write_en_o) begin
            mem[bus.mem_addr_o] <= bus.mem_data_o;
        end
    end
    assign bus.mem_data_i = mem[bus.mem_addr_o];

    // Expected memory contents and PC, tracked by the bench.
    logic [3:0] exp_mem [16];
    logic [3:0] pc_m;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_mem[i] = 4'h0;
        exp_mem[0] = 4'b1110;
        exp_mem[1] = 4'b0101;
        exp_mem[2] = 4'b1010;
        pc_m = 4'h0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe/valid counters and protocol invariants, sampled mid-cycle.
    int         rd_cnt = 0, wr_cnt = 0, fv_cnt = 0, dv_cnt = 0;
    logic [3:0] wr_addr = 4'h0, wr_data = 4'h0;
    always @(negedge clk_i) begin
        if (!reset_i) begin
            check_eq("rd_wr_exclusive", {31'd0, bus.mem_read_en_o & bus.mem_write_en_o}, 0);
            check_eq("strobe_with_valid", {31'd0, (bus.mem_read_en_o | bus.mem_write_en_o)
                     & (bus.fetch_valid_o | bus.data_valid_o)}, 0);
            check_eq("port_idle_nonzero", {31'd0, !(bus.mem_read_en_o | bus.mem_write_en_o)
                     && (bus.mem_addr_o != 0 || bus.mem_data_o != 0)}, 0);
            check_eq("not_busy_active", {31'd0, !bus.busy_o && (bus.mem_read_en_o
                     | bus.mem_write_en_o | bus.fetch_valid_o | bus.data_valid_o)}, 0);
            if (bus.mem_read_en_o) rd_cnt++;
            if (bus.mem_write_en_o) begin
                wr_cnt++;
                wr_addr = bus.mem_addr_o;
                wr_data = bus.mem_data_o;
            end
            if (bus.fetch_valid_o) fv_cnt++;
            if (bus.data_valid_o) dv_cnt++;
        end
    end

    // Waits (bounded) for the chosen valid; n counts negedges from the request cycle.
    task automatic wait_valid(input bit is_data, output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk_i);
            n++;
            got = is_data ? bus.data_valid_o : bus.fetch_valid_o;
        end
        if (!got) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic do_fetch(output int lat);
        @(posedge clk_i); #1;
        bus.fetch_req_i = 1'b1;
        wait_valid(1'b0, lat);
        @(posedge clk_i); #1;
        bus.fetch_req_i = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [3:0] a, input logic [3:0] d,
                           output int lat);
        @(posedge clk_i); #1;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = we;
        bus.data_addr_i  = a;
        bus.data_wdata_i = d;
        wait_valid(1'b1, lat);
        @(posedge clk_i); #1;
        bus.data_req_i = 1'b0;
    endtask

    task automatic do_jump(input logic [3:0] a);
        @(posedge clk_i); #1;
        bus.jump_en_i   = 1'b1;
        bus.jump_addr_i = a;
        @(posedge clk_i); #1;
        bus.jump_en_i = 1'b0;
    endtask

    int lat, rd0, wr0, fv0, dv0;
    logic [3:0] ra, rd_v;

    initial begin
        bus.fetch_req_i  = 1'b0;
        bus.jump_en_i    = 1'b0;
        bus.jump_addr_i  = 4'h0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 4'h0;
        bus.data_wdata_i = 4'h0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_eq("rst_pc", {28'd0, bus.pc_o}, 0);
        check_eq("rst_instr", {28'd0, bus.instr_o}, 0);
        check_eq("rst_rdata", {28'd0, bus.data_rdata_o}, 0);
        check_eq("rst_outs", {24'd0, bus.mem_read_en_o, bus.mem_write_en_o, bus.fetch_valid_o,
                 bus.data_valid_o, bus.busy_o, 3'd0}, 0);
        check_eq("rst_port", {24'd0, bus.mem_addr_o, bus.mem_data_o}, 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        // Two back-to-back fetches; valid on the third negedge from the request cycle.
        rd0 = rd_cnt; fv0 = fv_cnt;
        do_fetch(lat);
        check_eq("f1_lat", lat, 3);
        check_eq("f1_instr", {28'd0, bus.instr_o}, 32'he);
        check_eq("f1_pc", {28'd0, bus.pc_o}, 1);
        do_fetch(lat);
        check_eq("f2_lat", lat, 3);
        check_eq("f2_instr", {28'd0, bus.instr_o}, 32'h5);
        check_eq("f2_pc", {28'd0, bus.pc_o}, 2);
        @(negedge clk_i);
        check_eq("f_pulses", fv_cnt - fv0, 2);
        check_eq("f_reads", rd_cnt - rd0, 2);
        pc_m = 4'h2;

        // Store 9 to C, then load it back.
        rd0 = rd_cnt; wr0 = wr_cnt; dv0 = dv_cnt;
        do_data(1'b1, 4'hc, 4'h9, lat);
        check_eq("st_lat", lat, 3);
        check_eq("st_rdata", {28'd0, bus.data_rdata_o}, 0);
        check_eq("st_wr_cnt", wr_cnt - wr0, 1);
        check_eq("st_wr_addr", {28'd0, wr_addr}, 32'hc);
        check_eq("st_wr_data", {28'd0, wr_data}, 32'h9);
        check_eq("st_no_read", rd_cnt - rd0, 0);
        exp_mem[12] = 4'h9;
        do_data(1'b0, 4'hc, 4'h0, lat);
        check_eq("ld_lat", lat, 3);
        check_eq("ld_rdata", {28'd0, bus.data_rdata_o}, 32'h9);
        check_eq("ld_instr_hold", {28'd0, bus.instr_o}, 32'h5);
        @(negedge clk_i);
        check_eq("d_pulses", dv_cnt - dv0, 2);

        // Jump to 15, fetch twice across the wrap.
        do_jump(4'hf);
        @(negedge clk_i);
        check_eq("jmp_pc", {28'd0, bus.pc_o}, 32'hf);
        check_eq("jmp_busy", {31'd0, bus.busy_o}, 0);
        do_fetch(lat);
        check_eq("wrap_instr", {28'd0, bus.instr_o}, 0);
        check_eq("wrap_pc", {28'd0, bus.pc_o}, 0);
        do_fetch(lat);
        check_eq("wrap2_instr", {28'd0, bus.instr_o}, 32'he);
        check_eq("wrap2_pc", {28'd0, bus.pc_o}, 1);
        pc_m = 4'h1;

        // Simultaneous fetch and load: data wins, fetch follows.
        fv0 = fv_cnt;
        @(posedge clk_i); #1;
        bus.fetch_req_i = 1'b1;
        bus.data_req_i  = 1'b1;
        bus.data_we_i   = 1'b0;
        bus.data_addr_i = 4'h2;
        wait_valid(1'b1, lat);
        check_eq("prio_lat", lat, 3);
        check_eq("prio_rdata", {28'd0, bus.data_rdata_o}, 32'ha);
        check_eq("prio_no_fetch", fv_cnt - fv0, 0);
        @(posedge clk_i); #1;
        bus.data_req_i = 1'b0;
        wait_valid(1'b0, lat);
        check_eq("prio_f_lat", lat, 3);
        check_eq("prio_f_instr", {28'd0, bus.instr_o}, 32'h5);
        @(posedge clk_i); #1;
        bus.fetch_req_i = 1'b0;
        check_eq("prio_f_pc", {28'd0, bus.pc_o}, 2);

        // Reset in the middle of a fetch.
        @(posedge clk_i); #1;
        bus.fetch_req_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("mid_rd_before", {31'd0, bus.mem_read_en_o}, 1);
        reset_i = 1'b1;
        #1;
        check_eq("mid_rd_dropped", {31'd0, bus.mem_read_en_o}, 0);
        check_eq("mid_busy", {31'd0, bus.busy_o}, 0);
        check_eq("mid_pc", {28'd0, bus.pc_o}, 0);
        check_eq("mid_instr", {28'd0, bus.instr_o}, 0);
        bus.fetch_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("mid_no_valid", {31'd0, bus.fetch_valid_o}, 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        model_reset();

        // Random traffic against the bench's memory/PC model.
        for (int it = 0; it < 40; it++) begin
            ra   = 4'($urandom_range(0, 15));
            rd_v = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin
                    do_jump(ra);
                    pc_m = ra;
                    check_eq("rnd_jmp_pc", {28'd0, bus.pc_o}, {28'd0, pc_m});
                end
                1: begin
                    do_fetch(lat);
                    check_eq("rnd_f_instr", {28'd0, bus.instr_o}, {28'd0, exp_mem[pc_m]});
                    pc_m = pc_m + 4'd1;
                    check_eq("rnd_f_pc", {28'd0, bus.pc_o}, {28'd0, pc_m});
                end
                2: begin
                    do_data(1'b1, ra, rd_v, lat);
                    exp_mem[ra] = rd_v;
                    check_eq("rnd_st_rdata", {28'd0, bus.data_rdata_o}, 0);
                end
                default: begin
                    do_data(1'b0, ra, 4'h0, lat);
                    check_eq("rnd_ld_rdata", {28'd0, bus.data_rdata_o}, {28'd0, exp_mem[ra]});
                end
            endcase
            check_eq("rnd_lat", lat, 3);
        end

        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
